fetch_unit: RTL

//   Instruction fetch stage. Owns the PC, drives the word address of the synchronous-read

---
 rtl/fetch_unit.sv | 102 ++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, synchronous imem addressing, one-entry stall buffer, redirect.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (trap on misaligned redirect targets instead of truncating them).
module fetch_unit #(
   parameter int          ADDR_WIDTH = 5,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [31:0]           imem_data,
   input  logic                  redirect_valid,
   input  logic [31:0]           redirect_pc,
   input  logic                  instr_ready,
   output logic                  instr_valid,
   output logic [31:0]           instr,
   output logic [31:0]           instr_pc,
   output logic [31:0]           fetch_pc,
   output logic                  misalign_fault
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] out_pc_q, out_pc_d;
   logic        req_v_q, req_v_d;
   logic        hold_v_q, hold_v_d;
   logic [31:0] hold_q, hold_d;
   logic [31:0] target;
   logic        fault_q;
   logic        stall;
   logic        issue;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic fault_d;

   assign target = redirect_pc;

   always_ff @(posedge clk) begin
      if (!rst_n) fault_q <= 1'b0;
      else        fault_q <= fault_d;
   end

   always_comb begin
      fault_d = fault_q;
      if (redirect_valid) fault_d = (redirect_pc[1:0] != 2'b00);
   end
`else
   assign target  = redirect_pc & 32'hFFFF_FFFC;
   assign fault_q = 1'b0;
`endif

   // The imem always samples pc_q; pc_q only moves on issue/redirect, so a stalled
   // cycle re-reads the next word harmlessly while the held copy is shown.
   assign imem_addr      = pc_q[ADDR_WIDTH+1:2];
   assign instr_valid    = rst_n & (req_v_q | hold_v_q);
   assign instr          = !rst_n ? 32'h0 : (hold_v_q ? hold_q : (req_v_q ? imem_data : 32'h0));
   assign instr_pc       = rst_n ? out_pc_q : 32'h0;
   assign fetch_pc       = pc_q;
   assign misalign_fault = rst_n & fault_q;

   assign stall = instr_valid & ~instr_ready;
   assign issue = ~redirect_valid & ~stall & ~fault_q;

   always_comb begin
      pc_d     = pc_q;
      out_pc_d = out_pc_q;
      req_v_d  = req_v_q;
      hold_v_d = hold_v_q;
      hold_d   = hold_q;
      if (redirect_valid) begin
         pc_d     = target;
         req_v_d  = 1'b0;
         hold_v_d = 1'b0;
      end else if (issue) begin
         out_pc_d = pc_q;
         pc_d     = pc_q + 32'd4;
         req_v_d  = 1'b1;
         hold_v_d = 1'b0;
      end else if (stall) begin
         if (!hold_v_q) begin
            hold_d   = imem_data;
            hold_v_d = 1'b1;
         end
         req_v_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q     <= RESET_PC;
         out_pc_q <= 32'h0;
         req_v_q  <= 1'b0;
         hold_v_q <= 1'b0;
         hold_q   <= 32'h0;
      end else begin
         pc_q     <= pc_d;
         out_pc_q <= out_pc_d;
         req_v_q  <= req_v_d;
         hold_v_q <= hold_v_d;
         hold_q   <= hold_d;
      end
   end

endmodule
